// File: rtl/mips_multicycle_ctrl.sv
// Multicycle sequencing controller for the MIPS datapath: walks each instruction
// through fetch/decode/execute/memory/writeback and drives datapath enables and muxes.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 (waits on memory)
// DECODE | register read, branch target precompute, dispatch on op
// MEMADR | effective address for lw/sw
// MEMRD  | data memory read (waits on memory)
// MEMWB  | load result to rt
// MEMWR  | data memory write (waits on memory)
// EXEC   | R-type ALU operation
// ALUWB  | R-type result to rd
// BRANCH | beq compare and conditional PC load
// ADDIEX | addi ALU operation
// ADDIWB | addi result to rt
// JUMP   | PC load from jump target
// HALT   | unsupported encoding trapped, held until reset
module mips_multicycle_ctrl #(
   parameter bit USE_MEM_READY = 1'b1,
   parameter bit ILLEGAL_TRAP  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       branch,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       regdst,
   output logic       memtoreg,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       halted,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_ADDIEX = 4'd9;
   localparam logic [3:0] S_ADDIWB = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;
   localparam logic [3:0] S_HALT   = 4'd12;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic       rdy;
   logic       r_legal;
   logic [3:0] illegal_next;

   assign rdy          = mem_ready | ~USE_MEM_READY;
   assign r_legal      = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
   assign illegal_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;
   assign state        = state_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (rdy) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = r_legal ? S_EXEC : illegal_next;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = illegal_next;
            endcase
         end
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (rdy) state_d = S_MEMWB;
         S_MEMWR:  if (rdy) state_d = S_FETCH;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pcwrite    = 1'b0;
      branch     = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      iord       = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      pcsrc      = 2'b00;
      alucontrol = 3'b010;
      halted     = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrcb = 2'b01;
            irwrite = rdy;
            pcwrite = rdy;
         end
         S_DECODE: alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            case (funct)
               FN_SUB:  alucontrol = 3'b110;
               FN_AND:  alucontrol = 3'b000;
               FN_OR:   alucontrol = 3'b001;
               FN_SLT:  alucontrol = 3'b111;
               default: alucontrol = 3'b010;
            endcase
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = 3'b110;
            pcsrc      = 2'b01;
            branch     = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB: regwrite = 1'b1;
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
      // a reset cycle abandons the instruction: no write may leak out, even mid-MEMWR
      if (reset) begin
         pcwrite  = 1'b0;
         branch   = 1'b0;
         irwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction-level bench: a driver expands each instruction into its expected
// per-cycle control trace and queues it; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                          S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7,
                          S_BRANCH = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11,
                          S_HALT = 4'd12;

   typedef struct packed {
      logic [3:0] st;
      logic       halted, pcwrite, branch, irwrite, memwrite, regwrite, iord, alusrca;
      logic [1:0] alusrcb;
      logic       regdst, memtoreg;
      logic [1:0] pcsrc;
      logic [2:0] alucontrol;
   } obs_t;

   typedef struct packed {
      logic chk;
      obs_t o;
   } exp_t;

   logic       clk;
   logic       reset0, reset1;
   logic [5:0] op, funct;
   logic       mem_ready;

   logic       d0_pcwrite, d0_branch, d0_irwrite, d0_memwrite, d0_regwrite, d0_iord, d0_alusrca;
   logic       d0_regdst, d0_memtoreg, d0_halted;
   logic [1:0] d0_alusrcb, d0_pcsrc;
   logic [2:0] d0_alucontrol;
   logic [3:0] d0_state;
   logic       d1_pcwrite, d1_branch, d1_irwrite, d1_memwrite, d1_regwrite, d1_iord, d1_alusrca;
   logic       d1_regdst, d1_memtoreg, d1_halted;
   logic [1:0] d1_alusrcb, d1_pcsrc;
   logic [2:0] d1_alucontrol;
   logic [3:0] d1_state;

   obs_t obs0, obs1;

   mips_multicycle_ctrl #(.USE_MEM_READY(1'b1), .ILLEGAL_TRAP(1'b1)) dut0 (
      .clk(clk), .reset(reset0), .op(op), .funct(funct), .mem_ready(mem_ready),
      .pcwrite(d0_pcwrite), .branch(d0_branch), .irwrite(d0_irwrite), .memwrite(d0_memwrite),
      .regwrite(d0_regwrite), .iord(d0_iord), .alusrca(d0_alusrca), .alusrcb(d0_alusrcb),
      .regdst(d0_regdst), .memtoreg(d0_memtoreg), .pcsrc(d0_pcsrc), .alucontrol(d0_alucontrol),
      .halted(d0_halted), .state(d0_state)
   );

   mips_multicycle_ctrl #(.USE_MEM_READY(1'b0), .ILLEGAL_TRAP(1'b0)) dut1 (
      .clk(clk), .reset(reset1), .op(op), .funct(funct), .mem_ready(mem_ready),
      .pcwrite(d1_pcwrite), .branch(d1_branch), .irwrite(d1_irwrite), .memwrite(d1_memwrite),
      .regwrite(d1_regwrite), .iord(d1_iord), .alusrca(d1_alusrca), .alusrcb(d1_alusrcb),
      .regdst(d1_regdst), .memtoreg(d1_memtoreg), .pcsrc(d1_pcsrc), .alucontrol(d1_alucontrol),
      .halted(d1_halted), .state(d1_state)
   );

   assign obs0 = {d0_state, d0_halted, d0_pcwrite, d0_branch, d0_irwrite, d0_memwrite, d0_regwrite,
                  d0_iord, d0_alusrca, d0_alusrcb, d0_regdst, d0_memtoreg, d0_pcsrc, d0_alucontrol};
   assign obs1 = {d1_state, d1_halted, d1_pcwrite, d1_branch, d1_irwrite, d1_memwrite, d1_regwrite,
                  d1_iord, d1_alusrca, d1_alusrcb, d1_regdst, d1_memtoreg, d1_pcsrc, d1_alucontrol};

   initial clk = 1'b1;
   always #5 clk = ~clk;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cycle_no = 0;
   bit   active = 1'b0;
   bit   sel = 1'b0;
   bit   use_rdy = 1'b1;
   bit   trap = 1'b1;
   int   step_no, abort_at;
   bit   aborted;

   always @(negedge clk) begin
      exp_t e;
      obs_t a;
      cycle_no++;
      if (active) begin
         a = sel ? obs1 : obs0;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL underflow cycle %0d: DUT output with no queued expectation", cycle_no);
         end else begin
            e = q.pop_front();
            if (e.chk) begin
               checks++;
               if (a !== e.o) begin
                  errors++;
                  $display("FAIL trace dut%0d cycle %0d: got state=%0d bits=%h, expected state=%0d bits=%h",
                           sel, cycle_no, a.st, a, e.o.st, e.o);
               end
            end
         end
      end
   end

   function automatic obs_t base(input logic [3:0] s);
      obs_t o;
      o = '0;
      o.st = s;
      o.alucontrol = 3'b010;
      return o;
   endfunction

   function automatic bit rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit r_legal(input logic [5:0] f);
      return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   task automatic cyc(input bit rst, input bit rdy, input obs_t e, input bit chk);
      if (rst) begin
         e.pcwrite = 1'b0; e.branch = 1'b0; e.irwrite = 1'b0; e.memwrite = 1'b0; e.regwrite = 1'b0;
      end
      if (sel) reset1 = rst;
      else     reset0 = rst;
      mem_ready = rdy;
      q.push_back({chk, e});
      @(posedge clk);
      #1;
   endtask

   task automatic emit(input bit rdy, input obs_t e);
      if (aborted) return;
      if (step_no == abort_at) begin
         cyc(1'b1, rdy, e, 1'b1);
         aborted = 1'b1;
      end else begin
         cyc(1'b0, rdy, e, 1'b1);
      end
      step_no++;
   endtask

   function automatic bit pick_rdy(input int stalls);
      return (stalls >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
   endfunction

   task automatic run_instr(input logic [5:0] op_i, input logic [5:0] funct_i);
      obs_t e;
      bit   r, eff, is_lw;
      int   stalls;
      aborted  = 1'b0;
      step_no  = 0;
      abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : 1000;
      stalls   = 0;
      do begin
         r     = pick_rdy(stalls);
         eff   = r | ~use_rdy;
         op    = 6'($urandom);
         funct = 6'($urandom);
         e = base(S_FETCH); e.alusrcb = 2'b01; e.irwrite = eff; e.pcwrite = eff;
         emit(r, e);
         stalls++;
      end while (!eff && !aborted);
      if (aborted) return;
      op    = op_i;
      funct = funct_i;
      e = base(S_DECODE); e.alusrcb = 2'b11;
      emit(rnd(), e);
      is_lw = (op_i == 6'b100011);
      if (is_lw || op_i == 6'b101011) begin
         e = base(S_MEMADR); e.alusrca = 1'b1; e.alusrcb = 2'b10;
         emit(rnd(), e);
         stalls = 0;
         do begin
            r   = pick_rdy(stalls);
            eff = r | ~use_rdy;
            e = base(is_lw ? S_MEMRD : S_MEMWR); e.iord = 1'b1; e.memwrite = !is_lw;
            emit(r, e);
            stalls++;
         end while (!eff && !aborted);
         if (is_lw) begin
            e = base(S_MEMWB); e.memtoreg = 1'b1; e.regwrite = 1'b1;
            emit(rnd(), e);
         end
      end else if (op_i == 6'b000000 && r_legal(funct_i)) begin
         e = base(S_EXEC); e.alusrca = 1'b1; e.alucontrol = alu_of(funct_i);
         emit(rnd(), e);
         e = base(S_ALUWB); e.regdst = 1'b1; e.regwrite = 1'b1;
         emit(rnd(), e);
      end else if (op_i == 6'b000100) begin
         e = base(S_BRANCH); e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.branch = 1'b1;
         emit(rnd(), e);
      end else if (op_i == 6'b001000) begin
         e = base(S_ADDIEX); e.alusrca = 1'b1; e.alusrcb = 2'b10;
         emit(rnd(), e);
         e = base(S_ADDIWB); e.regwrite = 1'b1;
         emit(rnd(), e);
      end else if (op_i == 6'b000010) begin
         e = base(S_JUMP); e.pcsrc = 2'b10; e.pcwrite = 1'b1;
         emit(rnd(), e);
      end else if (trap) begin
         e = base(S_HALT); e.halted = 1'b1;
         for (int i = 0; i < 20; i++) emit(rnd(), e);
         if (!aborted) cyc(1'b1, rnd(), e, 1'b1);
      end
   endtask

   task automatic random_instr();
      logic [5:0] fl [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [5:0] o, f;
      f = 6'($urandom);
      case ($urandom_range(0, 9))
         0:       o = 6'b100011;
         1:       o = 6'b101011;
         4:       o = 6'b000100;
         5:       o = 6'b001000;
         6:       o = 6'b000010;
         7: begin
            do o = 6'($urandom); while (o inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43});
         end
         8: begin
            o = 6'b000000;
            do f = 6'($urandom); while (r_legal(f));
         end
         default: begin
            o = 6'b000000;
            f = fl[$urandom_range(0, 4)];
         end
      endcase
      run_instr(o, f);
   endtask

   initial begin
      obs_t e;
      reset0 = 1'b1; reset1 = 1'b1; op = '0; funct = '0; mem_ready = 1'b1;
      active = 1'b1;
      e = base(S_FETCH); e.alusrcb = 2'b01;
      cyc(1'b1, 1'b1, e, 1'b0);
      cyc(1'b1, 1'b1, e, 1'b1);
      run_instr(6'b000000, 6'b100000);
      run_instr(6'b100011, 6'b000000);
      run_instr(6'b101011, 6'b000000);
      run_instr(6'b000100, 6'b000000);
      run_instr(6'b000010, 6'b000000);
      run_instr(6'b111111, 6'b000000);
      for (int n = 0; n < 600; n++) random_instr();

      sel = 1'b1; use_rdy = 1'b0; trap = 1'b0; reset0 = 1'b1;
      e = base(S_FETCH); e.alusrcb = 2'b01;
      cyc(1'b1, 1'b0, e, 1'b1);
      run_instr(6'b111111, 6'b000000);
      run_instr(6'b000000, 6'b000001);
      for (int n = 0; n < 150; n++) random_instr();

      active = 1'b0;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unconsumed, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
